// File: rtl/issue_scoreboard_pkg.sv
// ----------------------------------------------------------------------------
// issue_scoreboard_pkg
// Shared types and default constants for the register-hazard scoreboard.
//   lat_type_t : latency class of an issued writer (ALU, LD, MUL, DIV)
//   SB_*       : default register count, register-index width, countdown
//                width and fixed latencies for loads and multiplies
// ----------------------------------------------------------------------------
package issue_scoreboard_pkg;

   typedef enum logic [1:0] {
      LAT_ALU = 2'd0,
      LAT_LD  = 2'd1,
      LAT_MUL = 2'd2,
      LAT_DIV = 2'd3
   } lat_type_t;

   localparam int SB_NREG    = 32;
   localparam int SB_RW      = 5;
   localparam int SB_CNT_W   = 3;
   localparam int SB_LD_LAT  = 2;
   localparam int SB_MUL_LAT = 3;

endpackage

// File: rtl/issue_scoreboard_if.sv
// ----------------------------------------------------------------------------
// issue_scoreboard_if
// Bundle between the dual-issue dispatcher and the hazard scoreboard.
//   flush                : kill younger instructions, issue inputs ignored
//   iss_*                : instructions actually issued (slot A = [1], B = [0])
//   cand_*               : candidates the dispatcher wants to issue next
//   div_done / div_rd    : divider writeback
//   lock_a / lock_b      : candidate must be held this cycle
//   div_busy / busy_vec  : divider outstanding, per-register busy
// modport master = dispatcher side, modport slave = scoreboard side.
// ----------------------------------------------------------------------------
interface issue_scoreboard_if
   import issue_scoreboard_pkg::*;
#(
   parameter int NREG = SB_NREG
);
   logic             flush;
   logic [1:0]       iss_valid;
   logic [SB_RW-1:0] iss_rd_a;
   logic [SB_RW-1:0] iss_rd_b;
   logic             iss_we_a;
   logic             iss_we_b;
   lat_type_t        iss_lat_a;
   lat_type_t        iss_lat_b;
   logic [1:0]       cand_valid;
   logic [SB_RW-1:0] cand_ra1_a;
   logic [SB_RW-1:0] cand_ra2_a;
   logic [SB_RW-1:0] cand_rd_a;
   logic [SB_RW-1:0] cand_ra1_b;
   logic [SB_RW-1:0] cand_ra2_b;
   logic [SB_RW-1:0] cand_rd_b;
   logic             cand_div_a;
   logic             cand_div_b;
   logic             div_done;
   logic [SB_RW-1:0] div_rd;
   logic             lock_a;
   logic             lock_b;
   logic             div_busy;
   logic [NREG-1:0]  busy_vec;

   modport master (
      output flush, iss_valid, iss_rd_a, iss_rd_b, iss_we_a, iss_we_b,
             iss_lat_a, iss_lat_b, cand_valid, cand_ra1_a, cand_ra2_a,
             cand_rd_a, cand_ra1_b, cand_ra2_b, cand_rd_b, cand_div_a,
             cand_div_b, div_done, div_rd,
      input  lock_a, lock_b, div_busy, busy_vec
   );

   modport slave (
      input  flush, iss_valid, iss_rd_a, iss_rd_b, iss_we_a, iss_we_b,
             iss_lat_a, iss_lat_b, cand_valid, cand_ra1_a, cand_ra2_a,
             cand_rd_a, cand_ra1_b, cand_ra2_b, cand_rd_b, cand_div_a,
             cand_div_b, div_done, div_rd,
      output lock_a, lock_b, div_busy, busy_vec
   );
endinterface

// File: rtl/issue_scoreboard_sb_entry.sv
// ----------------------------------------------------------------------------
// sb_entry
// Hazard state of one architectural register: a countdown for fixed-latency
// writers (cnt) and a pending flag for the variable-latency divider (pend).
//   clk, rstn : clock, asynchronous active-low reset
//   flush     : clears pend; the countdown keeps running
//   wr, lat   : a writer to this register issued this cycle, and its class
//   clr       : divider writeback targets this register
//   busy      : register must not be read/written by a candidate
// Optional: SB_FWD_EARLY_EN releases busy in the final countdown cycle and
// in the cycle the divider writes back.
// ----------------------------------------------------------------------------
module sb_entry
   import issue_scoreboard_pkg::*;
#(
   parameter int CNT_W   = SB_CNT_W,
   parameter int LD_LAT  = SB_LD_LAT,
   parameter int MUL_LAT = SB_MUL_LAT
) (
   input  logic      clk,
   input  logic      rstn,
   input  logic      flush,
   input  logic      wr,
   input  lat_type_t lat,
   input  logic      clr,
   output logic      busy
);
   localparam logic [CNT_W-1:0] LD_CNT  = CNT_W'(LD_LAT);
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);

   logic [CNT_W-1:0] cnt;
   logic             pend;

   // wr already excludes flush, so a new writer always overrides the
   // countdown and any same-cycle divider clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt  <= '0;
         pend <= 1'b0;
      end else if (wr) begin
         case (lat)
            LAT_LD:  begin cnt <= LD_CNT;  pend <= 1'b0; end
            LAT_MUL: begin cnt <= MUL_CNT; pend <= 1'b0; end
            LAT_DIV: begin cnt <= '0;      pend <= 1'b1; end
            default: begin cnt <= '0;      pend <= 1'b0; end
         endcase
      end else begin
         if (cnt != '0) cnt <= cnt - 1'b1;
         if (flush || clr) pend <= 1'b0;
      end
   end

`ifdef SB_FWD_EARLY_EN
   assign busy = (cnt > CNT_W'(1)) | (pend & ~clr);
`else
   assign busy = (cnt != '0) | pend;
`endif

endmodule

// File: rtl/issue_scoreboard.sv
// ----------------------------------------------------------------------------
// issue_scoreboard
// Register-hazard scoreboard beside the dual-issue dispatch stage. Tracks
// in-flight loads, multiplies and the single divider and produces per-slot
// lock signals from registered state.
//   clk  : clock
//   rstn : asynchronous active-low reset
//   sb   : issue_scoreboard_if.slave (issue, candidate, divider, lock bus)
// Optional: SB_FWD_EARLY_EN (see sb_entry) lets consumers issue during the
// last countdown cycle / divider writeback cycle.
// ----------------------------------------------------------------------------
module issue_scoreboard
   import issue_scoreboard_pkg::*;
#(
   parameter int NREG    = SB_NREG,
   parameter int CNT_W   = SB_CNT_W,
   parameter int LD_LAT  = SB_LD_LAT,
   parameter int MUL_LAT = SB_MUL_LAT
) (
   input logic               clk,
   input logic               rstn,
   issue_scoreboard_if.slave sb
);
   localparam logic [CNT_W-1:0] LD_CNT  = CNT_W'(LD_LAT);
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);

   logic [NREG-1:0] busy_vec;
   logic            wr_a;
   logic            wr_b;
   logic            div_iss;
   logic            div_busy_q;
   logic            lock_a_int;
   logic            lock_b_own;

   // Only real writers to a non-zero rd, and never during a flush.
   assign wr_a = ~sb.flush & sb.iss_valid[1] & sb.iss_we_a & (sb.iss_rd_a != '0);
   assign wr_b = ~sb.flush & sb.iss_valid[0] & sb.iss_we_b & (sb.iss_rd_b != '0);
   assign div_iss = (wr_a & (sb.iss_lat_a == LAT_DIV)) |
                    (wr_b & (sb.iss_lat_b == LAT_DIV));

   assign busy_vec[0] = 1'b0;

   for (genvar r = 1; r < NREG; r++) begin : g_ent
      logic      hit_a;
      logic      hit_b;
      lat_type_t lat;
      assign hit_a = wr_a & (sb.iss_rd_a == SB_RW'(r));
      assign hit_b = wr_b & (sb.iss_rd_b == SB_RW'(r));
      // Slot B is the younger instruction, so its class wins on a shared rd.
      assign lat   = hit_b ? sb.iss_lat_b : sb.iss_lat_a;

      sb_entry #(
         .CNT_W   (CNT_W),
         .LD_LAT  (LD_LAT),
         .MUL_LAT (MUL_LAT)
      ) u_ent (
         .clk   (clk),
         .rstn  (rstn),
         .flush (sb.flush),
         .wr    (hit_a | hit_b),
         .lat   (lat),
         .clr   (sb.div_done & (sb.div_rd == SB_RW'(r))),
         .busy  (busy_vec[r])
      );
   end

   // A flush kills the divider; a new divide beats a same-cycle completion.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         div_busy_q <= 1'b0;
      end else if (sb.flush) begin
         div_busy_q <= 1'b0;
      end else if (div_iss) begin
         div_busy_q <= 1'b1;
      end else if (sb.div_done) begin
         div_busy_q <= 1'b0;
      end
   end

   assign lock_a_int = sb.cand_valid[1] &
                       (busy_vec[sb.cand_ra1_a] | busy_vec[sb.cand_ra2_a] |
                        busy_vec[sb.cand_rd_a]  | (sb.cand_div_a & div_busy_q));
   assign lock_b_own = sb.cand_valid[0] &
                       (busy_vec[sb.cand_ra1_b] | busy_vec[sb.cand_ra2_b] |
                        busy_vec[sb.cand_rd_b]  | (sb.cand_div_b & div_busy_q));

   // B is in program order behind A and must never overtake a held A.
   assign sb.lock_a   = lock_a_int;
   assign sb.lock_b   = lock_b_own | lock_a_int;
   assign sb.div_busy = div_busy_q;
   assign sb.busy_vec = busy_vec;

   // A latency that truncates to zero would never mark the register busy.
   a_lat_nonzero: assert property (@(posedge clk) (LD_CNT != '0) && (MUL_CNT != '0));

endmodule

// File: tb/tb_issue_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_issue_scoreboard
// Directed bench for issue_scoreboard. Stimulus pushes the expected outputs
// of each checked cycle into a queue; a monitor on the falling edge pops and
// compares against the DUT.
// ----------------------------------------------------------------------------
module tb_issue_scoreboard;
   import issue_scoreboard_pkg::*;

`ifdef SB_FWD_EARLY_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   localparam int TIMEOUT_CYC = 2000;

   typedef struct {
      string       name;
      logic        la;
      logic        lb;
      logic        db;
      logic [31:0] bv;
   } exp_t;

   logic clk;
   logic rstn;
   logic done;
   exp_t q[$];
   int   tests  = 0;
   int   failed = 0;

   issue_scoreboard_if #(.NREG(32)) sbi ();

   issue_scoreboard dut (
      .clk  (clk),
      .rstn (rstn),
      .sb   (sbi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: compare every queued expectation at the falling edge.
   always @(negedge clk) begin
      exp_t e;
      while (q.size() != 0) begin
         e = q.pop_front();
         tests++;
         if (sbi.lock_a !== e.la || sbi.lock_b !== e.lb ||
             sbi.div_busy !== e.db || sbi.busy_vec !== e.bv) begin
            failed++;
            $display("FAIL %s: lock_a/lock_b/div_busy/busy_vec got %b/%b/%b/%h, expected %b/%b/%b/%h",
                     e.name, sbi.lock_a, sbi.lock_b, sbi.div_busy, sbi.busy_vec,
                     e.la, e.lb, e.db, e.bv);
         end
      end
   end

   // Watchdog: the stimulus must complete within the cycle budget.
   initial begin
      done = 1'b0;
      fork
         wait (done === 1'b1);
         repeat (TIMEOUT_CYC) @(posedge clk);
      join_any
      disable fork;
      tests++;
      if (done !== 1'b1) begin
         failed++;
         $display("FAIL timeout: stimulus did not finish within %0d cycles", TIMEOUT_CYC);
         $display("[TB] %0d tests run, %0d failed", tests, failed);
         $finish;
      end
   end

   task automatic clr_in();
      sbi.flush      = 1'b0;
      sbi.iss_valid  = 2'b00;
      sbi.iss_rd_a   = '0;
      sbi.iss_rd_b   = '0;
      sbi.iss_we_a   = 1'b0;
      sbi.iss_we_b   = 1'b0;
      sbi.iss_lat_a  = LAT_ALU;
      sbi.iss_lat_b  = LAT_ALU;
      sbi.cand_valid = 2'b00;
      sbi.cand_ra1_a = '0;
      sbi.cand_ra2_a = '0;
      sbi.cand_rd_a  = '0;
      sbi.cand_ra1_b = '0;
      sbi.cand_ra2_b = '0;
      sbi.cand_rd_b  = '0;
      sbi.cand_div_a = 1'b0;
      sbi.cand_div_b = 1'b0;
      sbi.div_done   = 1'b0;
      sbi.div_rd     = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string n, input logic la, input logic lb,
                             input logic db, input logic [31:0] bv);
      exp_t e;
      e.name = n;
      e.la   = la;
      e.lb   = lb;
      e.db   = db;
      e.bv   = bv;
      q.push_back(e);
   endtask

   initial begin
      clr_in();
      rstn = 1'b0;
      repeat (2) step();
      expect_out("rst_init", 0, 0, 0, 32'h0);
      step();
      rstn = 1'b1;
      step();

      // Load to r5 from slot A, candidate A reads r5
      sbi.iss_valid = 2'b10; sbi.iss_rd_a = 5; sbi.iss_we_a = 1; sbi.iss_lat_a = LAT_LD;
      sbi.cand_valid = 2'b10; sbi.cand_ra1_a = 5;
      expect_out("ld_c0", 0, 0, 0, 32'h0);
      step();
      sbi.iss_valid = 2'b00;
      expect_out("ld_c1", 1, 1, 0, 32'h20);
      step();
      expect_out("ld_c2", !FWD, !FWD, 0, FWD ? 32'h0 : 32'h20);
      step();
      expect_out("ld_c3", 0, 0, 0, 32'h0);
      clr_in();
      step();

      // Same rd in both slots: B decides
      sbi.iss_valid = 2'b11; sbi.iss_rd_a = 7; sbi.iss_rd_b = 7;
      sbi.iss_we_a = 1; sbi.iss_we_b = 1; sbi.iss_lat_a = LAT_MUL; sbi.iss_lat_b = LAT_ALU;
      step();
      clr_in();
      sbi.cand_valid = 2'b10; sbi.cand_rd_a = 7;
      expect_out("same_rd_b_alu", 0, 0, 0, 32'h0);
      sbi.iss_valid = 2'b11; sbi.iss_rd_a = 7; sbi.iss_rd_b = 7;
      sbi.iss_we_a = 1; sbi.iss_we_b = 1; sbi.iss_lat_a = LAT_ALU; sbi.iss_lat_b = LAT_MUL;
      step();
      sbi.iss_valid = 2'b00;
      expect_out("same_rd_b_mul", 1, 1, 0, 32'h80);
      repeat (3) step();
      expect_out("mul_done", 0, 0, 0, 32'h0);
      clr_in();
      step();

      // Divide to r9 from slot B, candidate B reads r9
      sbi.iss_valid = 2'b01; sbi.iss_rd_b = 9; sbi.iss_we_b = 1; sbi.iss_lat_b = LAT_DIV;
      step();
      sbi.iss_valid = 2'b00;
      sbi.cand_valid = 2'b01; sbi.cand_ra2_b = 9;
      for (int i = 0; i < 20; i++) begin
         expect_out($sformatf("div_hold%0d", i), 0, 1, 1, 32'h200);
         step();
      end
      sbi.cand_ra2_b = 1; sbi.cand_ra1_b = 2; sbi.cand_rd_b = 3; sbi.cand_div_b = 1;
      expect_out("div_unit_busy", 0, 1, 1, 32'h200);
      step();
      sbi.cand_div_b = 0;
      expect_out("div_indep", 0, 0, 1, 32'h200);
      step();
      sbi.cand_ra2_b = 9; sbi.div_done = 1; sbi.div_rd = 9;
      step();
      sbi.div_done = 0;
      expect_out("div_done", 0, 0, 0, 32'h0);
      step();

      // Divide issue and completion to the same register in one cycle
      clr_in();
      sbi.iss_valid = 2'b10; sbi.iss_rd_a = 11; sbi.iss_we_a = 1; sbi.iss_lat_a = LAT_DIV;
      sbi.div_done = 1; sbi.div_rd = 11;
      step();
      clr_in();
      expect_out("div_set_wins", 0, 0, 1, 32'h800);
      step();
      sbi.div_done = 1; sbi.div_rd = 11;
      step();
      sbi.div_done = 0;
      expect_out("div_clr2", 0, 0, 0, 32'h0);
      step();

      // Flush with pending divide, older load counting, new load ignored
      sbi.iss_valid = 2'b11; sbi.iss_rd_a = 4; sbi.iss_we_a = 1; sbi.iss_lat_a = LAT_LD;
      sbi.iss_rd_b = 10; sbi.iss_we_b = 1; sbi.iss_lat_b = LAT_DIV;
      step();
      clr_in();
      expect_out("pre_flush", 0, 0, 1, 32'h410);
      sbi.flush = 1; sbi.iss_valid = 2'b10; sbi.iss_rd_a = 3; sbi.iss_we_a = 1; sbi.iss_lat_a = LAT_LD;
      step();
      clr_in();
      expect_out("flush", 0, 0, 0, FWD ? 32'h0 : 32'h10);
      step();
      expect_out("flush_after", 0, 0, 0, 32'h0);
      step();

      // B held behind A; r0 never tracked or locked
      sbi.iss_valid = 2'b11; sbi.iss_rd_a = 5; sbi.iss_we_a = 1; sbi.iss_lat_a = LAT_LD;
      sbi.iss_rd_b = 0; sbi.iss_we_b = 1; sbi.iss_lat_b = LAT_LD;
      step();
      clr_in();
      sbi.cand_valid = 2'b11; sbi.cand_ra2_a = 5;
      sbi.cand_ra1_b = 1; sbi.cand_ra2_b = 2; sbi.cand_rd_b = 3;
      expect_out("b_behind_a", 1, 1, 0, 32'h20);
      step();
      sbi.cand_ra2_a = 0; sbi.cand_ra1_b = 0; sbi.cand_ra2_b = 0; sbi.cand_rd_b = 0;
      expect_out("r0_never", 0, 0, 0, FWD ? 32'h0 : 32'h20);
      step();
      clr_in();
      step();

      // Asynchronous reset while r5 is busy
      sbi.iss_valid = 2'b10; sbi.iss_rd_a = 5; sbi.iss_we_a = 1; sbi.iss_lat_a = LAT_LD;
      step();
      sbi.iss_valid = 2'b00;
      sbi.cand_valid = 2'b10; sbi.cand_ra1_a = 5;
      expect_out("pre_rst", 1, 1, 0, 32'h20);
      step();
      rstn = 1'b0;
      #1;
      tests++;
      if (sbi.busy_vec !== 32'h0 || sbi.lock_a !== 1'b0) begin
         failed++;
         $display("FAIL async_rst_immediate: busy_vec/lock_a got %h/%b, expected 0/0 without a clock",
                  sbi.busy_vec, sbi.lock_a);
      end
      expect_out("async_rst", 0, 0, 0, 32'h0);
      step();
      rstn = 1'b1;
      clr_in();
      step();

      @(negedge clk);
      #1;
      done = 1'b1;
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Register-hazard scoreboard sitting beside the dual-issue dispatch stage.
- Tracks in-flight long-latency writers: loads, multiplies (fixed latency) and the single divider (variable latency).
- Drives per-slot lock signals that the dispatcher uses to hold slot A/B. Replaces the single-entry last-load interlock with a full 32-entry tracker.
- Updated by the instructions the dispatcher actually issues, by divider completion, and by pipeline flush.

Parameters:
- NREG, 32, architectural registers; r0 is never tracked.
- CNT_W, 3, per-register countdown width.
- LD_LAT, 2, cycles from load issue until the result is forwardable (1..2^CNT_W-1).
- MUL_LAT, 3, same for multiply (1..2^CNT_W-1).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- flush  in  1  kill younger instructions; issue inputs ignored this cycle
- iss_valid  in  2  [1]=slot A issued, [0]=slot B issued (dispatcher o_usingNUM decoded)
- iss_rd_a / iss_rd_b  in  5  destination of issued instruction
- iss_we_a / iss_we_b  in  1  issued instruction writes rd
- iss_lat_a / iss_lat_b  in  2  lat_type_t: ALU, LD, MUL, DIV
- cand_valid  in  2  candidate validity, A/B
- cand_ra1_a, cand_ra2_a, cand_rd_a, cand_ra1_b, cand_ra2_b, cand_rd_b  in  5 each  candidate source/dest registers
- cand_div_a / cand_div_b  in  1  candidate is a divide
- div_done  in  1  divider result written back this cycle
- div_rd  in  5  divider destination
- lock_a / lock_b  out  1  candidate must not issue this cycle
- div_busy  out  1  divide outstanding
- busy_vec  out  NREG  per-register busy

Behaviour:
- Reset (async, rstn=0): all cnt=0, all pend=0, div_busy=0. Hence busy_vec=0, lock_a=0, lock_b=0.
- Per-register state:
  - IDLE: cnt=0, pend=0.
  - COUNT: cnt>0.
  - WAIT_WB: pend=1; only divides enter this state.
- Each cycle, every non-zero cnt decrements by 1 (COUNT to IDLE when it reaches 0).
- Issue, when flush=0 and iss_valid[x]=1 and iss_we_x=1 and rd!=0:
  - LD: cnt=LD_LAT, pend=0.
  - MUL: cnt=MUL_LAT, pend=0.
  - DIV: pend=1, cnt=0, div_busy=1.
  - ALU: cnt=0, pend=0 (writer supersedes).
- Issue takes precedence over decrement on the same register.
- Both slots writing the same rd: slot B (younger) determines the state.
- div_done clears pend[div_rd] and div_busy next cycle. A same-cycle DIV issue (both set and clear) wins, leaving pend=1 and div_busy=1.
- flush=1:
  - All iss_* ignored.
  - All pend cleared and div_busy cleared; the divider is killed by the same flush.
  - COUNT entries keep counting, because they belong to older instructions already past EX.
- busy(r) = (r!=0) & (cnt[r]!=0 | pend[r]).
- lock_x = cand_valid[x] & (busy(ra1) | busy(ra2) | busy(rd) | (cand_div_x & div_busy)).
- lock_b additionally ORs lock_a, so B never issues past a held A.
- lock outputs and busy_vec are combinational from registered state; a write at edge N affects the locks seen in cycle N+1.
- State update uses the issue, flush and div inputs seen at the edge.
- Counter width: LD_LAT and MUL_LAT are truncated to CNT_W bits. A value of 0 is illegal; this is asserted in simulation.

Optional Feature:
- SB_FWD_EARLY_EN
  - Defined: busy(r) uses cnt[r]>1 instead of cnt[r]!=0, so a consumer issues in the final countdown cycle via WB-stage forwarding. div_done with a matching div_rd is also treated as not busy in the same cycle (combinational clear).
  - Undefined: behaviour exactly as above, with no same-cycle relief.

Decomposition:
- Shared package Public_Info holds:
  - typedef enum logic[1:0] lat_type_t {LAT_ALU, LAT_LD, LAT_MUL, LAT_DIV};
  - constants SB_NREG, SB_LD_LAT, SB_MUL_LAT.
- One sub-module, sb_entry: a single register's cnt/pend state machine with its set/decrement/clear logic, instantiated NREG-1 times via generate.

Test Plan:
- Reset mid-run with r5 busy → rstn low: busy_vec=0 and lock_a=0 immediately, without waiting for a clock.
- Issue LD to r5 (LD_LAT=2) at cycle 0; candidate A reads r5 → lock_a=1 in cycles 1–2, 0 in cycle 3. With SB_FWD_EARLY_EN: lock_a=1 in cycle 1 only.
- Slot A MUL to r7 and slot B ALU to r7 in the same cycle → r7 not busy next cycle (B wins).
- DIV to r9 issued; candidate B reads r9 for 20 cycles → lock_b=1 throughout. Pulse div_done with div_rd=9 → lock_b=0 next cycle, div_busy=0.
- DIV pending and flush=1 alongside a LD issue to r3 → pend cleared, div_busy=0, r3 not busy (issue ignored). An older LD to r4 keeps counting.
- Candidate A locked on r5 while candidate B is independent → lock_b=1. Candidates reading r0 with r0 as a "written" rd → never locked.
